// File: rtl/mdu_pkg.sv
// Shared CPU definitions: ALU and MDU operation encodings plus default MDU latencies.
package mdu_pkg;

   typedef enum logic [3:0] {
      AluAdd  = 4'b0000,
      AluSub  = 4'b0001,
      AluAnd  = 4'b0010,
      AluOr   = 4'b0011,
      AluXor  = 4'b0100,
      AluNor  = 4'b0101,
      AluSlt  = 4'b0110,
      AluSltu = 4'b0111,
      AluSll  = 4'b1000,
      AluSrl  = 4'b1001,
      AluSra  = 4'b1010,
      AluLui  = 4'b1011
   } alu_op_e;

   typedef enum logic [2:0] {
      MdMult  = 3'b000,
      MdMultu = 3'b001,
      MdDiv   = 3'b010,
      MdDivu  = 3'b011,
      MdMthi  = 3'b100,
      MdMtlo  = 3'b101,
      MdMfhi  = 3'b110,
      MdMflo  = 3'b111
   } mdu_op_e;

   localparam int unsigned MULT_CYCLES_DEF = 5;
   localparam int unsigned DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/mdu.sv
// Multiply/divide unit with HI/LO registers. Operands are captured at start, the
// result is computed behaviourally from the captured operands and committed to
// HI/LO on the last edge of a fixed-latency busy window.
module mdu
   import mdu_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic [2:0]  MDU_op,
   input  logic        start,
   output logic        busy,
   output logic [31:0] MDU_result
);

   localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

   mdu_op_e            op;
   mdu_op_e            op_q;
   logic [31:0]        a_q, b_q;
   logic [31:0]        hi_q, lo_q;
   logic [CNT_W-1:0]   cnt_q;

   logic [63:0]        prod;
   logic               a_neg, b_neg;
   logic [31:0]        a_mag, b_mag;
   logic [31:0]        quo_mag, rem_mag;
   logic [31:0]        quo, rem;

   assign op   = mdu_op_e'(MDU_op);
   assign busy = (cnt_q != '0);

   // Behavioural datapath on the captured operands; only sampled at commit.
   always_comb begin
      prod    = '0;
      a_neg   = 1'b0;
      b_neg   = 1'b0;
      if (op_q == MdMult) begin
         prod = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
      end else begin
         prod = {32'b0, a_q} * {32'b0, b_q};
      end
      // Signed divide via magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
      if (op_q == MdDiv) begin
         a_neg = a_q[31];
         b_neg = b_q[31];
      end
      a_mag   = a_neg ? (~a_q + 32'd1) : a_q;
      b_mag   = b_neg ? (~b_q + 32'd1) : b_q;
      quo_mag = (b_mag != '0) ? (a_mag / b_mag) : '0;
      rem_mag = (b_mag != '0) ? (a_mag % b_mag) : '0;
      quo     = (a_neg ^ b_neg) ? (~quo_mag + 32'd1) : quo_mag;
      rem     = a_neg ? (~rem_mag + 32'd1) : rem_mag;
   end

   // Operation launch, countdown and HI/LO commit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hi_q  <= '0;
         lo_q  <= '0;
         a_q   <= '0;
         b_q   <= '0;
         op_q  <= MdMult;
         cnt_q <= '0;
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - 1'b1;
         if (cnt_q == CNT_W'(1)) begin
            if ((op_q == MdMult) || (op_q == MdMultu)) begin
               hi_q <= prod[63:32];
               lo_q <= prod[31:0];
            end else if (b_q != '0) begin
               hi_q <= rem;
               lo_q <= quo;
            end
         end
      end else if (start) begin
         case (op)
            MdMult, MdMultu: begin
               a_q   <= A;
               b_q   <= B;
               op_q  <= op;
               cnt_q <= CNT_W'(MULT_CYCLES);
            end
            MdDiv, MdDivu: begin
               a_q   <= A;
               b_q   <= B;
               op_q  <= op;
               cnt_q <= CNT_W'(DIV_CYCLES);
            end
            MdMthi:  hi_q <= A;
            MdMtlo:  lo_q <= A;
            default: ;
         endcase
      end
   end

   // Move-from reads are combinational and independent of start.
   always_comb begin
      MDU_result = '0;
      if (op == MdMfhi) begin
         MDU_result = hi_q;
      end else if (op == MdMflo) begin
         MDU_result = lo_q;
      end
   end

endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5: busy cycles for MULT/MULTU.
REQ-002 SHALL have parameter DIV_CYCLES, default 10: busy cycles for DIV/DIVU.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port A, input, 32: operand rs (dividend / multiplicand / MTHI-MTLO source).
REQ-006 SHALL have port B, input, 32: operand rt (divisor / multiplier).
REQ-007 SHALL have port MDU_op, input, 3: operation code, decoded only when start=1.
REQ-008 SHALL have port start, input, 1: one-cycle request strobe from the E stage.
REQ-009 SHALL have port busy, output, 1: high while a multiply or divide is in flight.
REQ-010 SHALL have port MDU_result, output, 32: HI for MFHI, LO for MFLO, otherwise 0.

Function
REQ-011 SHALL decode MDU_op as MULT=000, MULTU=001, DIV=010, DIVU=011, MTHI=100, MTLO=101, MFHI=110, MFLO=111.
REQ-012 SHALL capture A and B on an edge where start=1 and busy=0 with a MULT/MULTU/DIV/DIVU op, then assert busy from the next cycle for exactly MULT_CYCLES or DIV_CYCLES cycles.
REQ-013 SHALL write HI and LO on the edge that ends the busy window, and SHALL deassert busy in the cycle after that edge.
REQ-014 SHALL compute MULT as a signed 32x32->64 product and MULTU as an unsigned product, with HI = bits 63:32 and LO = bits 31:0.
REQ-015 SHALL compute DIV as signed, with the quotient truncated toward zero to LO and the remainder (sign of the dividend) to HI; DIVU SHALL be the unsigned equivalent.
REQ-016 SHALL leave HI and LO unchanged when the divisor is 0; busy SHALL still run the full DIV_CYCLES.
REQ-017 SHALL treat signed DIV of 0x80000000 by 0xFFFFFFFF as LO=0x80000000, HI=0.
REQ-018 SHALL, for MTHI/MTLO with start=1 and busy=0, write A into HI/LO on the same edge with no busy assertion.
REQ-019 SHALL drive MDU_result combinationally from current HI/LO when MDU_op is MFHI/MFLO, regardless of start; for any other op it SHALL drive 0.
REQ-020 SHALL ignore start (any op, including MTHI/MTLO) while busy=1; the pipeline stalls externally.
REQ-021 SHALL drive the internal countdown counter from the latency value to 0, with no wrap-around; busy = (count != 0).
REQ-022 SHALL make HI/LO read during busy return the pre-operation values.

Reset
REQ-023 SHALL, on assertion of reset (asynchronous), clear HI, LO and the counter to 0, and force busy=0.
REQ-024 SHALL, on reset mid-operation, abandon the operation with no HI/LO write after reset release.
REQ-025 SHALL accept a start in the first clock edge after reset deasserts.

Structure
REQ-026 SHALL have MDU_op encodings and the default latency constants in the shared CPU definitions package, alongside the ALU_op encodings.
REQ-027 SHALL be a single module with no sub-module; the multiply/divide datapath SHALL use behavioural operators on registered operands, and the result SHALL be committed at the end of the window.

Verification
REQ-028 SHALL cover MULT: A=0xFFFFFFFE (-2), B=3, start -> busy high 5 cycles, then HI=0xFFFFFFFF and LO=0xFFFFFFFA.
REQ-029 SHALL cover MULTU with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
REQ-030 SHALL cover DIV: A=-7, B=2 -> busy 10 cycles, then LO=0xFFFFFFFD (-3) and HI=0xFFFFFFFF (-1); DIVU with A=7, B=2 -> LO=3, HI=1.
REQ-031 SHALL cover divide by zero: MTHI 0x1234, MTLO 0x5678, then DIV with B=0 -> busy 10 cycles, HI=0x1234 and LO=0x5678 unchanged.
REQ-032 SHALL cover a start and an MTLO during busy: both ignored, busy count unaffected, and only the first operation's result is written.
REQ-033 SHALL cover reset at cycle 3 of a MULT: busy=0 and HI=LO=0 immediately, and they stay 0 after release with no late write.
